// File: rtl/lipsi_pkg.sv
// Shared constants and select encodings for the 1-to-3 demultiplexer.
package lipsi_pkg;

  // Default narrow channel width and wide channel width (carry in the MSB).
  localparam int DEMUX_DW = 8;
  localparam int DEMUX_WW = DEMUX_DW + 1;

  // Destination select encoding carried on in_sel.
  typedef enum logic [1:0] {
    SEL_CH0 = 2'd0,
    SEL_CH1 = 2'd1,
    SEL_CH2 = 2'd2,
    SEL_BAD = 2'd3
  } sel_e;

endpackage

// File: rtl/out_slot.sv
// One-entry output holding register with valid/ready drain.
// A load always wins: loading on the same edge as a drain keeps the slot
// full with the new word, so a channel sustains one word per cycle.
module out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot occupancy and payload; payload only changes on a load or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to3.sv
// 1-to-3 demultiplexer with one holding slot per channel.
// ch0/ch1 carry DW bits (carry bit dropped), ch2 carries the full WW-bit word.
// Select value 3 is accepted and dropped, raising the sticky err_sel flag.
// Optional build macro DEMUX1TO3_ERRCNT_EN adds the saturating err_cnt port.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and in_ready never looks at in_valid
// (it depends only on in_sel, slot occupancy and the selected out ready).
module demux1to3 #(
  parameter int DW = lipsi_pkg::DEMUX_DW,
  parameter int WW = lipsi_pkg::DEMUX_WW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [WW-1:0] in_data,
  input  logic [1:0]    in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [WW-1:0] out2_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic          err_sel
`ifdef DEMUX1TO3_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  import lipsi_pkg::*;

  logic in_fire;
  logic load0;
  logic load1;
  logic load2;
  logic bad_fire;

  // Accept when the selected slot is free or draining this cycle; bad
  // selects are always accepted so they can be dropped; nothing in reset.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (sel_e'(in_sel))
        SEL_CH0: in_ready = !out0_valid || out0_ready;
        SEL_CH1: in_ready = !out1_valid || out1_ready;
        SEL_CH2: in_ready = !out2_valid || out2_ready;
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign load0    = in_fire && (in_sel == SEL_CH0);
  assign load1    = in_fire && (in_sel == SEL_CH1);
  assign load2    = in_fire && (in_sel == SEL_CH2);
  assign bad_fire = in_fire && (in_sel == SEL_BAD);

  out_slot #(.WIDTH(DW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data[DW-1:0]),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data)
  );

  out_slot #(.WIDTH(DW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data[DW-1:0]),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data)
  );

  out_slot #(.WIDTH(WW)) u_slot2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load2),
    .load_data (in_data),
    .ready     (out2_ready),
    .valid     (out2_valid),
    .data      (out2_data)
  );

  // Sticky flag: set by the first dropped word, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else if (bad_fire) begin
      err_sel <= 1'b1;
    end
  end

`ifdef DEMUX1TO3_ERRCNT_EN
  // Dropped-word counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (bad_fire && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to3.sv
// Self-checking bench for demux1to3: directed scenarios plus a randomized
// run scored against per-channel expected queues.
module tb_demux1to3;

  logic       clk;
  logic       rst_n;
  logic [8:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [8:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic       err_sel;
`ifdef DEMUX1TO3_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel is a queue of words awaiting delivery.
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [8:0] exp_q2[$];
  bit         m_err;
  int         m_cnt;

  demux1to3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .err_sel    (err_sel)
`ifdef DEMUX1TO3_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model view of in_ready: a one-entry channel can take a word when empty
  // or when its current word leaves this cycle; bad selects always go.
  function automatic bit model_in_ready();
    if (!rst_n) return 1'b0;
    case (in_sel)
      2'd0:    return (exp_q0.size() == 0) || out0_ready;
      2'd1:    return (exp_q1.size() == 0) || out1_ready;
      2'd2:    return (exp_q2.size() == 0) || out2_ready;
      default: return 1'b1;
    endcase
  endfunction

  // Advance one clock: decide transfers from the current inputs, step the
  // model at the edge, and return 1 time unit after the edge.
  task automatic cycle();
    bit         acc;
    bit         d0, d1, d2;
    logic [8:0] a_data;
    logic [1:0] a_sel;
    acc    = in_valid && model_in_ready();
    a_data = in_data;
    a_sel  = in_sel;
    d0 = out0_ready && (exp_q0.size() > 0);
    d1 = out1_ready && (exp_q1.size() > 0);
    d2 = out2_ready && (exp_q2.size() > 0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (d0) void'(exp_q0.pop_front());
      if (d1) void'(exp_q1.pop_front());
      if (d2) void'(exp_q2.pop_front());
      if (acc) begin
        case (a_sel)
          2'd0: exp_q0.push_back(a_data[7:0]);
          2'd1: exp_q1.push_back(a_data[7:0]);
          2'd2: exp_q2.push_back(a_data);
          default: begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        endcase
      end
    end
  endtask

  // Driver: idle input, all outputs ready, let slots drain.
  task automatic drain();
    in_valid = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic send(input logic [1:0] sel, input logic [8:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    m_err = 1'b0; m_cnt = 0;
    cycle();
    cycle();
    in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++; if ({out0_valid, out1_valid, out2_valid} !== 3'b000) begin n_errors++; $display("FAIL reset_valid got %b exp 000", {out0_valid, out1_valid, out2_valid}); end
    n_checks++; if ({out0_data, out1_data, out2_data} !== 25'd0) begin n_errors++; $display("FAIL reset_data got %h %h %h exp 0", out0_data, out1_data, out2_data); end
    n_checks++; if (err_sel !== 1'b0) begin n_errors++; $display("FAIL reset_err_sel got %b exp 0", err_sel); end
`ifdef DEMUX1TO3_ERRCNT_EN
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_route();
    drain();
    send(2'd0, 9'h1A5);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL route_in_ready got %b exp 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin n_errors++; $display("FAIL route_ch0 got v=%b d=%h exp v=1 d=a5", out0_valid, out0_data); end
    n_checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin n_errors++; $display("FAIL route_others got v1=%b v2=%b exp 0 0", out1_valid, out2_valid); end
    cycle();
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL route_drain got %b exp 0", out0_valid); end
  endtask

  task automatic test_carry();
    drain();
    send(2'd2, 9'h1FF);
    cycle();
    n_checks++; if (out2_valid !== 1'b1 || out2_data !== 9'h1FF) begin n_errors++; $display("FAIL carry_ch2 got v=%b d=%h exp v=1 d=1ff", out2_valid, out2_data); end
    send(2'd1, 9'h1FF);
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hFF) begin n_errors++; $display("FAIL carry_ch1 got v=%b d=%h exp v=1 d=ff", out1_valid, out1_data); end
  endtask

  task automatic test_backpressure();
    drain();
    out0_ready = 1'b0;
    send(2'd0, 9'h011);
    cycle();
    send(2'd0, 9'h022);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h11) begin n_errors++; $display("FAIL bp_hold1 got v=%b d=%h exp v=1 d=11", out0_valid, out0_data); end
    cycle();
    cycle();
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h11) begin n_errors++; $display("FAIL bp_hold2 got v=%b d=%h exp v=1 d=11", out0_valid, out0_data); end
    out0_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin n_errors++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=22", out0_valid, out0_data); end
    cycle();
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL bp_no_dup got %b exp 0", out0_valid); end
  endtask

  task automatic test_independence();
    drain();
    out0_ready = 1'b0;
    send(2'd0, 9'h044);
    cycle();
    send(2'd1, 9'h033);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL indep_in_ready got %b exp 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h33) begin n_errors++; $display("FAIL indep_ch1 got v=%b d=%h exp v=1 d=33", out1_valid, out1_data); end
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h44) begin n_errors++; $display("FAIL indep_ch0_hold got v=%b d=%h exp v=1 d=44", out0_valid, out0_data); end
    drain();
  endtask

  task automatic test_bad_sel();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    drain();
    n_checks++; if (err_sel !== 1'b0) begin n_errors++; $display("FAIL bad_pre_err got %b exp 0", err_sel); end
    for (int i = 0; i < 3; i++) begin
      send(2'd3, 9'($urandom_range(0, 511)));
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bad_in_ready[%0d] got %b exp 1", i, in_ready); end
      cycle();
    end
    in_valid = 1'b0;
    n_checks++; if ({out0_valid, out1_valid, out2_valid} !== 3'b000) begin n_errors++; $display("FAIL bad_no_valid got %b exp 000", {out0_valid, out1_valid, out2_valid}); end
    n_checks++; if (err_sel !== 1'b1) begin n_errors++; $display("FAIL bad_err_sel got %b exp 1", err_sel); end
`ifdef DEMUX1TO3_ERRCNT_EN
    n_checks++; if (err_cnt !== 8'd3) begin n_errors++; $display("FAIL bad_cnt3 got %0d exp 3", err_cnt); end
`endif
    send(2'd3, 9'h000);
    for (int i = 3; i < 300; i++) cycle();
    in_valid = 1'b0;
    cycle();
    n_checks++; if (err_sel !== 1'b1) begin n_errors++; $display("FAIL bad_err_sticky got %b exp 1", err_sel); end
`ifdef DEMUX1TO3_ERRCNT_EN
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL bad_cnt_sat got %0d exp 255", err_cnt); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    drain();
    out2_ready = 1'b0;
    send(2'd2, 9'h100);
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out2_valid !== 1'b1 || out2_data !== 9'h100) begin n_errors++; $display("FAIL rst_stall_hold got v=%b d=%h exp v=1 d=100", out2_valid, out2_data); end
    rst_n = 1'b0;
    send(2'd2, 9'h0AA);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_stall_in_ready got %b exp 0", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out2_valid !== 1'b0 || out2_data !== 9'h000) begin n_errors++; $display("FAIL rst_stall_ch2 got v=%b d=%h exp v=0 d=000", out2_valid, out2_data); end
    n_checks++; if (err_sel !== 1'b0) begin n_errors++; $display("FAIL rst_stall_err got %b exp 0", err_sel); end
    rst_n = 1'b1;
    out2_ready = 1'b1;
    cycle();
    n_checks++; if (out2_valid !== 1'b0) begin n_errors++; $display("FAIL rst_stall_ghost got %b exp 0", out2_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = 2'($urandom_range(0, 3));
      in_data    = 9'($urandom_range(0, 511));
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      out2_ready = ($urandom_range(0, 1) != 0);
      #1;
      n_checks++; if (in_ready !== model_in_ready()) begin n_errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", i, in_ready, model_in_ready()); end
      n_checks++; if ({out0_valid, out1_valid, out2_valid} !== {exp_q0.size() > 0, exp_q1.size() > 0, exp_q2.size() > 0}) begin
        n_errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, {out0_valid, out1_valid, out2_valid}, {exp_q0.size() > 0, exp_q1.size() > 0, exp_q2.size() > 0});
      end
      if (exp_q0.size() > 0) begin n_checks++; if (out0_data !== exp_q0[0]) begin n_errors++; $display("FAIL rnd_d0[%0d] got %h exp %h", i, out0_data, exp_q0[0]); end end
      if (exp_q1.size() > 0) begin n_checks++; if (out1_data !== exp_q1[0]) begin n_errors++; $display("FAIL rnd_d1[%0d] got %h exp %h", i, out1_data, exp_q1[0]); end end
      if (exp_q2.size() > 0) begin n_checks++; if (out2_data !== exp_q2[0]) begin n_errors++; $display("FAIL rnd_d2[%0d] got %h exp %h", i, out2_data, exp_q2[0]); end end
      n_checks++; if (err_sel !== m_err) begin n_errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, err_sel, m_err); end
`ifdef DEMUX1TO3_ERRCNT_EN
      n_checks++; if (err_cnt !== 8'(m_cnt)) begin n_errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, err_cnt, m_cnt); end
`endif
      cycle();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_route();
    test_carry();
    test_backpressure();
    test_independence();
    test_bad_sel();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1to3.md
DEMUX1TO3 -- requirements
Module: demux1to3

Interface
REQ-001 Parameter DW, default 8, narrow channel data width.
REQ-002 Parameter WW, default 9, wide channel data width (DW+1, carry in MSB).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  WW  source word; bit WW-1 is carry.
REQ-006 in_sel  input  2  destination select: 0=ch0, 1=ch1, 2=ch2, 3=invalid.
REQ-007 in_valid  input  1  in_data/in_sel valid.
REQ-008 in_ready  output  1  block accepts the current word.
REQ-009 out0_data  output  DW  ch0 data; out0_valid output 1; out0_ready input 1.
REQ-010 out1_data  output  DW  ch1 data; out1_valid output 1; out1_ready input 1.
REQ-011 out2_data  output  WW  ch2 data; out2_valid output 1; out2_ready input 1.
REQ-012 err_sel  output  1  sticky flag: a word with in_sel=3 was accepted.
REQ-013 err_cnt  output  8  dropped-word count; present only with DEMUX1TO3_ERRCNT_EN.

Function
REQ-014 Input transfer occurs when in_valid && in_ready at a rising edge; output transfer when outN_valid && outN_ready.
REQ-015 Each channel has one one-entry holding register (slot); outN_data/outN_valid are driven directly from the slot registers.
REQ-016 in_ready is combinational from in_sel and slot state only, never from in_valid: for sel 0..2, in_ready = !slot_valid[sel] || outN_ready[sel]; for sel=3, in_ready = 1.
REQ-017 Accepted word loads the selected slot; outN_valid rises the next cycle (latency 1 cycle, throughput 1 word/cycle per channel).
REQ-018 ch0/ch1 load in_data[DW-1:0]; bit WW-1 is discarded. ch2 loads all WW bits unchanged.
REQ-019 Same-edge drain and load on one slot: slot stays valid and holds the new word; no bubble.
REQ-020 Drain without load: outN_valid falls the next cycle.
REQ-021 While outN_valid && !outN_ready, outN_data and outN_valid hold stable.
REQ-022 Channels are independent: a stalled channel blocks only words selecting that channel.
REQ-023 Accepted word with in_sel=3 is dropped (no slot written) and sets err_sel the next cycle; err_sel stays 1 until reset.

Reset
REQ-024 When rst_n=0 at a rising edge, all outN_valid, all outN_data, err_sel (and err_cnt) become 0.
REQ-025 Reset mid-operation discards buffered words; no output transfer is reported for them after reset.
REQ-026 While rst_n=0, in_ready is forced to 0.

Configuration
REQ-027 With macro DEMUX1TO3_ERRCNT_EN defined, err_cnt exists and increments by 1 per accepted in_sel=3 word, saturating at 255.
REQ-028 Without DEMUX1TO3_ERRCNT_EN, the err_cnt port and its counter are absent; err_sel behaviour is unchanged.

Structure
REQ-029 Shared package lipsi_pkg holds DW/WW constants and select encodings SEL_CH0=0, SEL_CH1=1, SEL_CH2=2, SEL_BAD=3.
REQ-030 Sub-module out_slot (parameter width; load, data, ready in; valid, data out) is instantiated three times, with WW width for ch2.

Verification
REQ-031 Route: in_data=9'h1A5, sel=0, all ready=1 -> next cycle out0_data=8'hA5, out0_valid=1; ch1/ch2 valid stay 0.
REQ-032 Carry keep: in_data=9'h1FF, sel=2 -> out2_data=9'h1FF; with sel=1 -> out1_data=8'hFF.
REQ-033 Backpressure: out0_ready=0, two sel=0 words 8'h11 and 8'h22 -> first held at out0_data=8'h11; in_ready=0 for the second; after out0_ready=1, 8'h22 follows next cycle with no loss or duplication.
REQ-034 Independence: ch0 stalled and full, sel=1 word 8'h33 -> in_ready=1, out1_data=8'h33 next cycle.
REQ-035 Bad select: three sel=3 words -> in_ready=1, no outN_valid, err_sel=1; with DEMUX1TO3_ERRCNT_EN, err_cnt=3; 300 words -> err_cnt=255.
REQ-036 Reset mid-stall: ch2 holding 9'h100 with out2_ready=0, rst_n=0 for one edge -> out2_valid=0, out2_data=0, err_sel=0.
